// File: rtl/db15_pkg.sv
// rtl/db15_pkg.sv - shared types and bit-index constants for the SNAC DB15 scan sequencer
package db15_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOAD_REL,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        GAP
    } db15_state_t;

    localparam int FRAME_BITS  = 32;
    localparam int PLAYER_BITS = 16;

    // Joystick word bit positions, shared with the emu-level joystick muxing
    localparam int BIT_R  = 0;
    localparam int BIT_L  = 1;
    localparam int BIT_D  = 2;
    localparam int BIT_U  = 3;
    localparam int BIT_A  = 4;
    localparam int BIT_B  = 5;
    localparam int BIT_C  = 6;
    localparam int BIT_D2 = 7;
    localparam int BIT_E  = 8;
    localparam int BIT_F  = 9;
    localparam int BIT_L2 = 10;
    localparam int BIT_S  = 11;
    localparam int BIT_A2 = 12;
    localparam int BIT_B2 = 13;

endpackage

// File: rtl/db15_tick_gen.sv
// rtl/db15_tick_gen.sv - CLK_DIV divider with synchronous clear, emits a one-cycle tick
module db15_tick_gen #(
    parameter int CLK_DIV = 12
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int W = $clog2(CLK_DIV);

    logic [W-1:0] r_cnt;
    logic         w_at_end;

    assign w_at_end = (r_cnt == W'(CLK_DIV - 1));
    assign tick     = enable && !clear && w_at_end;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clear || !enable) begin
            r_cnt <= '0;
        end else if (w_at_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/db15_scan_sequencer.sv
// rtl/db15_scan_sequencer.sv - SNAC DB15 serial adapter scan FSM and joystick output registers
// Optional: DB15_DEBOUNCE_EN publishes a frame only when it matches the previously captured frame.
module db15_scan_sequencer
    import db15_pkg::*;
#(
    parameter int CLK_DIV   = 12,
    parameter int GAP_TICKS = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   JOY_DATA,
    output logic                   JOY_CLK,
    output logic                   JOY_LOAD,
    output logic [PLAYER_BITS-1:0] joystick1,
    output logic [PLAYER_BITS-1:0] joystick2,
    output logic                   frame_valid,
    output logic                   busy
);

    localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

    db15_state_t            r_state;
    logic                   r_sync1;
    logic                   r_sync2;
    logic [FRAME_BITS-1:0]  r_shift;
    logic [4:0]             r_bit;
    logic [GAP_W-1:0]       r_gap_cnt;
    logic                   r_joy_clk;
    logic                   r_joy_load;
    logic                   r_frame_valid;
    logic                   r_busy;
    logic [PLAYER_BITS-1:0] r_joy1;
    logic [PLAYER_BITS-1:0] r_joy2;
`ifdef DB15_DEBOUNCE_EN
    logic [FRAME_BITS-1:0]  r_prev_frame;
    logic                   r_prev_valid;
`endif

    logic w_tick;
    logic w_div_clear;
    logic w_sample;

    // LATCH takes no tick, so the divider restarts cleanly for GAP
    assign w_div_clear = (r_state == IDLE) || (r_state == LATCH);
    assign w_sample    = ~r_sync2;

    db15_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .clear   (w_div_clear),
        .tick    (w_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= JOY_DATA;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_shift       <= '0;
            r_bit         <= '0;
            r_gap_cnt     <= '0;
            r_joy_clk     <= 1'b1;
            r_joy_load    <= 1'b1;
            r_frame_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_joy1        <= '0;
            r_joy2        <= '0;
`ifdef DB15_DEBOUNCE_EN
            r_prev_frame  <= '0;
            r_prev_valid  <= 1'b0;
`endif
        end else if (!enable) begin
            r_state       <= IDLE;
            r_shift       <= '0;
            r_bit         <= '0;
            r_gap_cnt     <= '0;
            r_joy_clk     <= 1'b1;
            r_joy_load    <= 1'b1;
            r_frame_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_joy1        <= '0;
            r_joy2        <= '0;
`ifdef DB15_DEBOUNCE_EN
            r_prev_frame  <= '0;
            r_prev_valid  <= 1'b0;
`endif
        end else begin
            r_frame_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_state    <= LOAD;
                    r_joy_load <= 1'b0;
                    r_busy     <= 1'b1;
                end
                LOAD: begin
                    if (w_tick) begin
                        r_state    <= LOAD_REL;
                        r_joy_load <= 1'b1;
                    end
                end
                LOAD_REL: begin
                    if (w_tick) begin
                        r_state   <= SHIFT_LO;
                        r_bit     <= '0;
                        r_joy_clk <= 1'b0;
                        r_shift   <= {r_shift[FRAME_BITS-2:0], w_sample};
                    end
                end
                SHIFT_LO: begin
                    if (w_tick) begin
                        r_state   <= SHIFT_HI;
                        r_joy_clk <= 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (w_tick) begin
                        if (r_bit == 5'(FRAME_BITS - 1)) begin
                            r_state <= LATCH;
                        end else begin
                            r_state   <= SHIFT_LO;
                            r_bit     <= r_bit + 1'b1;
                            r_joy_clk <= 1'b0;
                            r_shift   <= {r_shift[FRAME_BITS-2:0], w_sample};
                        end
                    end
                end
                LATCH: begin
                    // First sample sits in the MSB: player 1 high half, player 2 low half
`ifdef DB15_DEBOUNCE_EN
                    if (r_prev_valid && (r_shift == r_prev_frame)) begin
                        r_joy1        <= r_shift[FRAME_BITS-1 -: PLAYER_BITS];
                        r_joy2        <= r_shift[PLAYER_BITS-1:0];
                        r_frame_valid <= 1'b1;
                    end
                    r_prev_frame <= r_shift;
                    r_prev_valid <= 1'b1;
`else
                    r_joy1        <= r_shift[FRAME_BITS-1 -: PLAYER_BITS];
                    r_joy2        <= r_shift[PLAYER_BITS-1:0];
                    r_frame_valid <= 1'b1;
`endif
                    r_busy    <= 1'b0;
                    r_gap_cnt <= '0;
                    r_state   <= GAP;
                end
                GAP: begin
                    if (w_tick) begin
                        if (r_gap_cnt == GAP_W'(GAP_TICKS - 1)) begin
                            r_state    <= LOAD;
                            r_joy_load <= 1'b0;
                            r_busy     <= 1'b1;
                            r_gap_cnt  <= '0;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign JOY_CLK     = r_joy_clk;
    assign JOY_LOAD    = r_joy_load;
    assign joystick1   = r_joy1;
    assign joystick2   = r_joy2;
    assign frame_valid = r_frame_valid;
    assign busy        = r_busy;

endmodule

// File: tb/tb_db15_scan_sequencer.sv
// tb/tb_db15_scan_sequencer.sv - self-checking bench with a behavioural DB15 adapter and frame model
module tb_db15_scan_sequencer;
    import db15_pkg::*;

    localparam int CLK_DIV    = 4;
    localparam int GAP_TICKS  = 8;
    localparam int FRAME_CLKS = (2 + 64 + GAP_TICKS) * CLK_DIV + 1;
`ifdef DB15_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    wire         JOY_DATA;
    logic        JOY_CLK;
    logic        JOY_LOAD;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic        frame_valid;
    logic        busy;

    int pass_cnt = 0;
    int check_cnt = 0;
    int cyc = 0;

    // Adapter: {P1,P2} active-low, P1 MSB first on JOY_DATA
    logic [31:0] adapter_word = '1;
    logic [31:0] ad_sr = '1;
    logic        ad_prev_clk = 1'b1;

    // Reference model state
    logic [15:0] exp_j1 = '0;
    logic [15:0] exp_j2 = '0;
    logic [31:0] prev_word = '0;
    bit          have_prev = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        ad_prev_clk <= JOY_CLK;
        if (!JOY_LOAD)
            ad_sr <= adapter_word;
        else if (JOY_CLK && !ad_prev_clk)
            ad_sr <= {ad_sr[30:0], 1'b1};
    end
    assign JOY_DATA = ad_sr[31];

    db15_scan_sequencer #(
        .CLK_DIV   (CLK_DIV),
        .GAP_TICKS (GAP_TICKS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .JOY_DATA    (JOY_DATA),
        .JOY_CLK     (JOY_CLK),
        .JOY_LOAD    (JOY_LOAD),
        .joystick1   (joystick1),
        .joystick2   (joystick2),
        .frame_valid (frame_valid),
        .busy        (busy)
    );

    task automatic model_clear();
        exp_j1    = '0;
        exp_j2    = '0;
        have_prev = 1'b0;
    endtask

    // Sample k is ~w[31-k]; k<16 lands on joystick1[15-k], k>=16 on joystick2[31-k]
    task automatic model_frame(input logic [31:0] w, output bit upd);
        upd = !DEB || (have_prev && (w == prev_word));
        if (upd) begin
            for (int k = 0; k < 32; k++) begin
                if (k < 16) exp_j1[15-k] = ~w[31-k];
                else        exp_j2[31-k] = ~w[31-k];
            end
        end
        prev_word = w;
        have_prev = 1'b1;
    endtask

    task automatic wait_frame_end(output int fv_count, output int end_cyc,
                                  output int low_cnt, output bit ok);
        bit seen_busy;
        seen_busy = 1'b0;
        fv_count  = 0;
        end_cyc   = 0;
        low_cnt   = 0;
        ok        = 1'b0;
        for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
            @(negedge clk);
            if (frame_valid === 1'b1) fv_count++;
            if (busy !== 1'b1) low_cnt++;
            if (busy === 1'b1) seen_busy = 1'b1;
            else if (seen_busy) begin
                ok      = 1'b1;
                end_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic do_frame(input logic [31:0] w, input string tag);
        bit upd, ok;
        int fvc, ec, lc;
        adapter_word = w;
        model_frame(w, upd);
        wait_frame_end(fvc, ec, lc, ok);
        check_cnt++;
        if (!ok) $display("FAIL %s_timeout frame end not seen", tag); else pass_cnt++;
        check_cnt++;
        if (fvc !== (upd ? 1 : 0)) $display("FAIL %s_fv got %0d pulses want %0d", tag, fvc, upd ? 1 : 0); else pass_cnt++;
        check_cnt++;
        if (joystick1 !== exp_j1) $display("FAIL %s_j1 got %h want %h", tag, joystick1, exp_j1); else pass_cnt++;
        check_cnt++;
        if (joystick2 !== exp_j2) $display("FAIL %s_j2 got %h want %h", tag, joystick2, exp_j2); else pass_cnt++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (3) @(negedge clk);
        check_cnt++;
        if (JOY_CLK !== 1'b1) $display("FAIL reset_joy_clk got %b want 1", JOY_CLK); else pass_cnt++;
        check_cnt++;
        if (JOY_LOAD !== 1'b1) $display("FAIL reset_joy_load got %b want 1", JOY_LOAD); else pass_cnt++;
        check_cnt++;
        if (joystick1 !== 16'h0 || joystick2 !== 16'h0) $display("FAIL reset_joy got %h %h want 0 0", joystick1, joystick2); else pass_cnt++;
        check_cnt++;
        if (frame_valid !== 1'b0 || busy !== 1'b0) $display("FAIL reset_fv_busy got %b %b want 0 0", frame_valid, busy); else pass_cnt++;
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check_cnt++;
        if (JOY_LOAD !== 1'b1 || busy !== 1'b0) $display("FAIL idle_disabled got load=%b busy=%b want 1 0", JOY_LOAD, busy); else pass_cnt++;
    endtask

    task automatic test_load_timing();
        int ll, cl, rises, run, run_min, run_max, fvc;
        bit pc, sb, ok, upd;
        ll = 0; cl = 0; rises = 0; run = 0; run_min = 9999; run_max = 0; fvc = 0;
        pc = 1'b1; sb = 1'b0; ok = 1'b0;
        adapter_word = {16'hFFFE, 16'hFFFF};
        model_frame(adapter_word, upd);
        enable = 1'b1;
        for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
            @(negedge clk);
            if (frame_valid === 1'b1) fvc++;
            if (JOY_LOAD === 1'b0) ll++;
            if (JOY_CLK === 1'b0) begin
                cl++;
                run++;
            end else if (run > 0) begin
                if (run < run_min) run_min = run;
                if (run > run_max) run_max = run;
                run = 0;
            end
            if (JOY_CLK === 1'b1 && !pc) rises++;
            pc = JOY_CLK;
            if (busy === 1'b1) sb = 1'b1;
            else if (sb) begin
                ok = 1'b1;
                break;
            end
        end
        check_cnt++;
        if (!ok) $display("FAIL first_frame_timeout frame end not seen"); else pass_cnt++;
        check_cnt++;
        if (ll !== CLK_DIV) $display("FAIL load_low_clks got %0d want %0d", ll, CLK_DIV); else pass_cnt++;
        check_cnt++;
        if (cl !== 32 * CLK_DIV) $display("FAIL joy_clk_low_clks got %0d want %0d", cl, 32 * CLK_DIV); else pass_cnt++;
        check_cnt++;
        if (rises !== 32) $display("FAIL joy_clk_rises got %0d want 32", rises); else pass_cnt++;
        check_cnt++;
        if (run_min !== CLK_DIV || run_max !== CLK_DIV) $display("FAIL joy_clk_half_period got %0d..%0d want %0d", run_min, run_max, CLK_DIV); else pass_cnt++;
        check_cnt++;
        if (fvc !== (upd ? 1 : 0)) $display("FAIL first_frame_fv got %0d want %0d", fvc, upd ? 1 : 0); else pass_cnt++;
        check_cnt++;
        if (joystick1 !== exp_j1 || joystick2 !== exp_j2) $display("FAIL first_frame_joy got %h %h want %h %h", joystick1, joystick2, exp_j1, exp_j2); else pass_cnt++;
        check_cnt++;
        if (joystick1[BIT_R] !== upd) $display("FAIL first_frame_bit_r got %b want %b", joystick1[BIT_R], upd); else pass_cnt++;
    endtask

    task automatic test_bit_order();
        do_frame({16'h7FFF, 16'hFFFE}, "order_a");
        do_frame({16'h7FFF, 16'hFFFE}, "order_b");
    endtask

    task automatic test_random();
        logic [31:0] w;
        w = $urandom;
        for (int n = 0; n < 8; n++) begin
            if ($urandom_range(0, 1) == 0) w = $urandom;
            do_frame(w, "random");
        end
    endtask

    task automatic test_enable_drop();
        int rises, fv_seen, load_seen;
        bit pc, ok, upd;
        int fvc, ec, lc;
        rises = 0; pc = JOY_CLK; fv_seen = 0; load_seen = 0;
        do_frame(32'h00FF_F0F0, "pre_drop_a");
        do_frame(32'h00FF_F0F0, "pre_drop_b");
        adapter_word = $urandom;
        for (int i = 0; i < 2 * FRAME_CLKS && rises < 10; i++) begin
            @(negedge clk);
            if (JOY_CLK === 1'b1 && !pc) rises++;
            pc = JOY_CLK;
        end
        check_cnt++;
        if (rises !== 10) $display("FAIL drop_reach_bit10 got %0d rises want 10", rises); else pass_cnt++;
        enable = 1'b0;
        model_clear();
        @(negedge clk);
        check_cnt++;
        if (JOY_CLK !== 1'b1 || JOY_LOAD !== 1'b1) $display("FAIL drop_lines got clk=%b load=%b want 1 1", JOY_CLK, JOY_LOAD); else pass_cnt++;
        check_cnt++;
        if (joystick1 !== 16'h0 || joystick2 !== 16'h0) $display("FAIL drop_joy got %h %h want 0 0", joystick1, joystick2); else pass_cnt++;
        check_cnt++;
        if (busy !== 1'b0 || frame_valid !== 1'b0) $display("FAIL drop_busy_fv got %b %b want 0 0", busy, frame_valid); else pass_cnt++;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (frame_valid !== 1'b0) fv_seen++;
            if (JOY_LOAD !== 1'b1) load_seen++;
        end
        check_cnt++;
        if (fv_seen !== 0 || load_seen !== 0) $display("FAIL drop_quiet got fv=%0d load_low=%0d want 0 0", fv_seen, load_seen); else pass_cnt++;
        model_frame(adapter_word, upd);
        enable = 1'b1;
        @(negedge clk);
        check_cnt++;
        if (JOY_LOAD !== 1'b0 || busy !== 1'b1) $display("FAIL reenable_load got load=%b busy=%b want 0 1", JOY_LOAD, busy); else pass_cnt++;
        wait_frame_end(fvc, ec, lc, ok);
        check_cnt++;
        if (!ok || fvc !== (upd ? 1 : 0)) $display("FAIL reenable_fv got ok=%b fv=%0d want 1 %0d", ok, fvc, upd ? 1 : 0); else pass_cnt++;
        check_cnt++;
        if (joystick1 !== exp_j1 || joystick2 !== exp_j2) $display("FAIL reenable_joy got %h %h want %h %h", joystick1, joystick2, exp_j1, exp_j2); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        int fvc, ec, lc, prev_ec;
        bit ok, upd;
        w = $urandom;
        do_frame(w, "period_prime_a");
        do_frame(w, "period_prime_b");
        prev_ec = -1;
        for (int n = 0; n < 3; n++) begin
            model_frame(w, upd);
            wait_frame_end(fvc, ec, lc, ok);
            check_cnt++;
            if (!ok || fvc !== 1) $display("FAIL period_fv frame %0d got ok=%b fv=%0d want 1 1", n, ok, fvc); else pass_cnt++;
            check_cnt++;
            if (lc !== GAP_TICKS * CLK_DIV) $display("FAIL period_busy_low frame %0d got %0d want %0d", n, lc, GAP_TICKS * CLK_DIV); else pass_cnt++;
            if (prev_ec >= 0) begin
                check_cnt++;
                if (ec - prev_ec !== FRAME_CLKS) $display("FAIL period_len frame %0d got %0d want %0d", n, ec - prev_ec, FRAME_CLKS); else pass_cnt++;
            end
            prev_ec = ec;
        end
    endtask

    task automatic test_async_reset();
        bit ok, upd;
        int fvc, ec, lc;
        repeat (50) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_cnt++;
        if (JOY_CLK !== 1'b1 || JOY_LOAD !== 1'b1) $display("FAIL areset_lines got clk=%b load=%b want 1 1", JOY_CLK, JOY_LOAD); else pass_cnt++;
        check_cnt++;
        if (joystick1 !== 16'h0 || joystick2 !== 16'h0 || busy !== 1'b0) $display("FAIL areset_outs got %h %h busy=%b want 0 0 0", joystick1, joystick2, busy); else pass_cnt++;
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
        model_frame(adapter_word, upd);
        wait_frame_end(fvc, ec, lc, ok);
        check_cnt++;
        if (!ok || fvc !== (upd ? 1 : 0)) $display("FAIL areset_restart got ok=%b fv=%0d want 1 %0d", ok, fvc, upd ? 1 : 0); else pass_cnt++;
        check_cnt++;
        if (joystick1 !== exp_j1 || joystick2 !== exp_j2) $display("FAIL areset_joy got %h %h want %h %h", joystick1, joystick2, exp_j1, exp_j2); else pass_cnt++;
    endtask

`ifdef DB15_DEBOUNCE_EN
    task automatic test_debounce();
        logic [31:0] a, b;
        a = 32'h1234_ABCD;
        b = 32'hFEDC_0F0F;
        do_frame(a, "deb_a_seed");
        do_frame(b, "deb_b_first");
        do_frame(b, "deb_b_second");
        check_cnt++;
        if (joystick1 !== 16'h0123 || joystick2 !== 16'hF0F0) $display("FAIL deb_b_value got %h %h want 0123 f0f0", joystick1, joystick2); else pass_cnt++;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_timing();
        test_bit_order();
        test_random();
        test_enable_drop();
        test_back_to_back();
`ifdef DB15_DEBOUNCE_EN
        test_debounce();
`endif
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
